// File: rtl/mcc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcc_pkg
// Brief    : Shared defaults, state encoding and helpers for the collector.
// Revision : 1.0 - initial release
// ============================================================================
package mcc_pkg;

    localparam int c_sample_w_def = 12;
    localparam int c_depth_def    = 64;
    localparam int c_num_ch_def   = 2;

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_cap_req    = 3'd1;
    localparam logic [2:0] c_st_cap_next   = 3'd2;
    localparam logic [2:0] c_st_send_fetch = 3'd3;
    localparam logic [2:0] c_st_send_req   = 3'd4;
    localparam logic [2:0] c_st_send_next  = 3'd5;
    localparam logic [2:0] c_st_done       = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE       = c_st_idle,
        ST_CAP_REQ    = c_st_cap_req,
        ST_CAP_NEXT   = c_st_cap_next,
        ST_SEND_FETCH = c_st_send_fetch,
        ST_SEND_REQ   = c_st_send_req,
        ST_SEND_NEXT  = c_st_send_next,
        ST_DONE       = c_st_done
    } state_e;

    // A single channel still needs a one-bit tag.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : mcc_pkg
`default_nettype wire

// File: rtl/mcc_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mcc_sample_buffer
// Brief    : DEPTH x SAMPLE_W simple dual-port RAM, synchronous write,
//            registered one-cycle read, no reset (block RAM friendly).
// Revision : 1.0 - initial release
// ============================================================================
module mcc_sample_buffer #(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] ram [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= ram[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : mcc_sample_buffer
`default_nettype wire

// File: rtl/multi_channel_collector.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_collector
// Brief    : Captures N round-robin ADC samples into a buffer, then sends them
//            to the Arduino link in order. MCC_CONTINUOUS_EN repeats runs.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_collector
    import mcc_pkg::*;
#(
    parameter int  SAMPLE_W = c_sample_w_def,
    parameter int  DEPTH    = c_depth_def,
    parameter int  NUM_CH   = c_num_ch_def,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     sample_count,
    output logic                busy,
    output logic                done,
    output logic                phase,
    output logic                adc_req,
    output logic [CH_W-1:0]     adc_ch,
    input  logic                adc_ack,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                tx_req,
    output logic [CH_W-1:0]     tx_ch,
    output logic [SAMPLE_W-1:0] tx_data,
    input  logic                tx_ack
);

    localparam logic [ADDR_W:0] c_depth_n   = (ADDR_W+1)'(DEPTH);
    localparam logic [CH_W-1:0] c_last_ch   = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [SAMPLE_W-1:0] w_rd_data;
    logic [ADDR_W:0]     w_cnt_inc;
    logic [CH_W-1:0]     w_ch_inc;
    logic                w_last;
    logic [ADDR_W:0]     w_n_start;

    assign w_cnt_inc = cnt_q + (ADDR_W+1)'(1);
    assign w_ch_inc  = (ch_q == c_last_ch) ? '0 : ch_q + CH_W'(1);
    assign w_last    = (w_cnt_inc == n_q);
    assign w_n_start = (sample_count > c_depth_n) ? c_depth_n : sample_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;

        // Abort outranks every ack and every start.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        n_d     = w_n_start;
                        cnt_d   = '0;
                        ch_d    = '0;
                        state_d = (w_n_start == '0) ? ST_DONE : ST_CAP_REQ;
                    end
                end
                ST_CAP_REQ: begin
                    if (adc_ack) begin
                        w_wr_en = 1'b1;
                        state_d = ST_CAP_NEXT;
                    end
                end
                ST_CAP_NEXT: begin
                    if (w_last) begin
                        cnt_d   = '0;
                        ch_d    = '0;
                        state_d = ST_SEND_FETCH;
                    end else begin
                        cnt_d   = w_cnt_inc;
                        ch_d    = w_ch_inc;
                        state_d = ST_CAP_REQ;
                    end
                end
                ST_SEND_FETCH: begin
                    w_rd_en = 1'b1;
                    state_d = ST_SEND_REQ;
                end
                ST_SEND_REQ: begin
                    if (tx_ack) begin
                        state_d = ST_SEND_NEXT;
                    end
                end
                ST_SEND_NEXT: begin
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = w_cnt_inc;
                        ch_d    = w_ch_inc;
                        state_d = ST_SEND_FETCH;
                    end
                end
                ST_DONE: begin
`ifdef MCC_CONTINUOUS_EN
                    if (n_q != '0) begin
                        cnt_d   = '0;
                        ch_d    = '0;
                        state_d = ST_CAP_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Read data is held by the RAM output register for the whole send request.
    mcc_sample_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_buffer (
        .clk      (clk),
        .wr_en    (w_wr_en),
        .wr_addr  (cnt_q[ADDR_W-1:0]),
        .wr_data  (adc_data),
        .rd_en    (w_rd_en),
        .rd_addr  (cnt_q[ADDR_W-1:0]),
        .rd_data  (w_rd_data)
    );

`ifdef MCC_CONTINUOUS_EN
    assign busy  = (state_q != ST_IDLE) && !((state_q == ST_DONE) && (n_q == '0));
`else
    assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif
    assign done    = (state_q == ST_DONE);
    assign phase   = (state_q == ST_SEND_FETCH) || (state_q == ST_SEND_REQ) ||
                     (state_q == ST_SEND_NEXT);
    assign adc_req = (state_q == ST_CAP_REQ);
    assign adc_ch  = adc_req ? ch_q : '0;
    assign tx_req  = (state_q == ST_SEND_REQ);
    assign tx_ch   = tx_req ? ch_q : '0;
    assign tx_data = tx_req ? w_rd_data : '0;

endmodule : multi_channel_collector
`default_nettype wire

// File: tb/tb_multi_channel_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_collector
// Brief    : Self-checking bench; behavioural scoreboard of capture order and
//            send order. Honours MCC_CONTINUOUS_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_collector;

    localparam int SW  = 12;
    localparam int DP  = 64;
    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  sample_count = '0;
    logic        busy, done, phase, adc_req, tx_req;
    logic [0:0]  adc_ch, tx_ch;
    logic        adc_ack = 1'b0;
    logic [11:0] adc_data = '0;
    logic [11:0] tx_data;
    logic        tx_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    multi_channel_collector #(.SAMPLE_W(SW), .DEPTH(DP), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sample_count(sample_count), .busy(busy), .done(done), .phase(phase),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
        .tx_req(tx_req), .tx_ch(tx_ch), .tx_data(tx_data), .tx_ack(tx_ack)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check(name, {busy, done, phase, adc_req, tx_req, adc_ch, tx_ch, tx_data}, 32'd0);
    endtask

    typedef struct {
        int sc; int adc_dmax; int tx_dmax; bit tx_fixed; bit fixed_data; bit spurious;
        int exp_cap; int exp_tx; int exp_done;
    } vec_t;

    // One complete run: the bench plays ADC and Arduino, scoring every request.
    task automatic do_run(input int sc, input int adc_dmax, input int tx_dmax,
                          input bit tx_fixed, input bit fixed_data, input bit spurious,
                          output int n_cap, output int n_tx, output int n_done);
        logic [11:0] q[$];
        logic [11:0] d;
        int cyc = 0, last_ack = -100, adc_cnt = -1, tx_cnt = -1;
        bit fin = 0;
        n_cap = 0; n_tx = 0; n_done = 0;
        @(negedge clk); start = 1'b1; sample_count = 7'(sc);
        @(negedge clk); start = 1'b0;
        while (!fin && cyc < 20000) begin
            adc_ack = 1'b0; tx_ack = 1'b0; start = 1'b0; abort = 1'b0;
            if (adc_req) begin
                check("adc_ch", 32'(adc_ch), 32'(n_cap % NCH));
                check("adc_req_phase", {31'd0, phase | tx_req}, 32'd0);
                if (adc_cnt < 0) adc_cnt = int'($urandom_range(0, adc_dmax));
                if (adc_cnt == 0) begin
                    d = fixed_data ? 12'(32'h111 * (n_cap + 1)) : 12'($urandom_range(0, 4095));
                    adc_data = d; adc_ack = 1'b1; q.push_back(d); n_cap++; adc_cnt = -1;
                end else adc_cnt--;
            end
            if (tx_req) begin
                check("tx_ch", 32'(tx_ch), 32'(n_tx % NCH));
                if (n_tx < q.size()) check("tx_data", 32'(tx_data), 32'(q[n_tx]));
                else check("tx_extra", 32'(n_tx), 32'(q.size()));
                if (tx_cnt < 0) tx_cnt = tx_fixed ? tx_dmax : int'($urandom_range(0, tx_dmax));
                if (tx_cnt == 0) begin
                    tx_ack = 1'b1; n_tx++; last_ack = cyc; tx_cnt = -1;
                end else tx_cnt--;
            end
            if (spurious && phase && !tx_req) begin
                adc_ack = 1'($urandom_range(0, 1));
                start = 1'b1; sample_count = 7'd1;
            end
            if (done) begin
                n_done++; fin = 1;
                if (n_tx > 0) check("done_after_ack", {31'd0, (cyc - last_ack >= 1) && (cyc - last_ack <= 2)}, 32'd1);
                check("done_reqs", {30'd0, adc_req, tx_req}, 32'd0);
`ifdef MCC_CONTINUOUS_EN
                check("done_busy", {31'd0, busy}, {31'd0, sc != 0});
                abort = 1'b1;
`else
                check("done_busy", {31'd0, busy}, 32'd0);
`endif
            end
            cyc++;
            @(negedge clk);
        end
        adc_ack = 1'b0; tx_ack = 1'b0; start = 1'b0; abort = 1'b0;
        if (!fin) check("run_timeout", 32'(cyc), 32'd0);
        check("post_done_idle", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vec_t vecs[11];
        int n_cap, n_tx, n_done, acks, cyc, m;

        vecs[0] = '{4,   0, 0,   0, 1, 0, 4,  4,  1};
        vecs[1] = '{0,   0, 0,   0, 0, 0, 0,  0,  1};
        vecs[2] = '{127, 1, 1,   0, 0, 0, 64, 64, 1};
        vecs[3] = '{1,   3, 3,   0, 0, 0, 1,  1,  1};
        vecs[4] = '{5,   2, 0,   0, 0, 0, 5,  5,  1};
        vecs[5] = '{64,  0, 2,   0, 0, 0, 64, 64, 1};
        vecs[6] = '{2,   0, 500, 1, 0, 1, 2,  2,  1};
        vecs[7] = '{65,  0, 0,   0, 0, 0, 64, 64, 1};
        for (int i = 8; i < 11; i++) begin
            m = int'($urandom_range(0, 127));
            vecs[i] = '{m, 2, 2, 0, 0, i == 9, (m < DP) ? m : DP, (m < DP) ? m : DP, 1};
        end

        // Reset held with start pulsed, then released.
        repeat (2) @(negedge clk);
        start = 1'b1; sample_count = 7'd4;
        @(negedge clk); check_quiet("reset_start");
        start = 1'b0;
        @(negedge clk); check_quiet("reset_held");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("post_reset_idle");

        for (int i = 0; i < 11; i++) begin
            do_run(vecs[i].sc, vecs[i].adc_dmax, vecs[i].tx_dmax, vecs[i].tx_fixed,
                   vecs[i].fixed_data, vecs[i].spurious, n_cap, n_tx, n_done);
            check($sformatf("v%0d_captures", i), 32'(n_cap), 32'(vecs[i].exp_cap));
            check($sformatf("v%0d_sends", i), 32'(n_tx), 32'(vecs[i].exp_tx));
            check($sformatf("v%0d_done", i), 32'(n_done), 32'(vecs[i].exp_done));
        end

        // Start and abort together: abort wins.
        @(negedge clk); start = 1'b1; abort = 1'b1; sample_count = 7'd3;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); check_quiet("start_abort_quiet");

        // Abort coinciding with the third adc_ack.
        @(negedge clk); start = 1'b1; sample_count = 7'd4;
        @(negedge clk); start = 1'b0;
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 200) begin
            adc_ack = 1'b0; abort = 1'b0;
            if (adc_req) begin
                adc_data = 12'($urandom_range(0, 4095)); adc_ack = 1'b1; acks++;
                if (acks == 3) abort = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        adc_ack = 1'b0; abort = 1'b0;
        check("abort_acks", 32'(acks), 32'd3);
        check("abort_idle", {29'd0, busy, done, adc_req, tx_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        do_run(2, 1, 1, 0, 0, 0, n_cap, n_tx, n_done);
        check("after_abort_cap", 32'(n_cap), 32'd2);
        check("after_abort_tx", 32'(n_tx), 32'd2);
        check("after_abort_done", 32'(n_done), 32'd1);

        // Reset asserted between clock edges mid-run.
        @(negedge clk); start = 1'b1; sample_count = 7'd5;
        @(negedge clk); start = 1'b0;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1 check_quiet("async_reset");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); check_quiet("async_reset_release");

`ifdef MCC_CONTINUOUS_EN
        // Continuous mode: repeated done pulses while busy stays up.
        @(negedge clk); start = 1'b1; sample_count = 7'd3;
        @(negedge clk); start = 1'b0;
        n_done = 0; cyc = 0;
        while (n_done < 3 && cyc < 2000) begin
            adc_ack = adc_req; tx_ack = tx_req; abort = 1'b0;
            adc_data = 12'($urandom_range(0, 4095));
            if (done) begin
                n_done++;
                check("cont_busy", {31'd0, busy}, 32'd1);
                if (n_done == 3) abort = 1'b1;
            end else if (cyc > 0) begin
                check("cont_busy_run", {31'd0, busy}, 32'd1);
            end
            cyc++;
            @(negedge clk);
        end
        adc_ack = 1'b0; tx_ack = 1'b0; abort = 1'b0;
        check("cont_dones", 32'(n_done), 32'd3);
        check("cont_abort_idle", {30'd0, busy, done}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_channel_collector
`default_nettype wire
